// File: rtl/leaf_out_arbiter_rr.sv
// leaf_out_arbiter_rr: round-robin arbiter from user streams onto one leaf output packet register,
// with per-port credit flow control and per-port sequence numbering.
module leaf_out_arbiter_rr #(
    parameter int NUM_OUT_PORTS = 6,
    parameter int PAYLOAD_BITS  = 32,
    parameter int NUM_LEAF_BITS = 5,
    parameter int NUM_PORT_BITS = 4,
    parameter int NUM_ADDR_BITS = 7,
    parameter int PACKET_BITS   = 49,
    parameter int CREDIT_BITS   = 8,
    parameter int CREDIT_INIT   = 64
) (
    input  logic                                                clk,
    input  logic                                                reset_n,
    input  logic [NUM_OUT_PORTS*PAYLOAD_BITS-1:0]               din_leaf_user2interface,
    input  logic [NUM_OUT_PORTS-1:0]                            vld_user2interface,
    output logic [NUM_OUT_PORTS-1:0]                            ack_interface2user,
    input  logic [NUM_OUT_PORTS*(NUM_LEAF_BITS+NUM_PORT_BITS)-1:0] dst_cfg,
    input  logic                                                credit_vld,
    input  logic [NUM_PORT_BITS-1:0]                            credit_port,
    input  logic [CREDIT_BITS-1:0]                              credit_amount,
    input  logic                                                stall,
    input  logic                                                resend,
    output logic [PACKET_BITS-1:0]                              dout_leaf_interface2bft,
    output logic [NUM_OUT_PORTS-1:0]                            credit_empty
);
    localparam int DST_BITS = NUM_LEAF_BITS + NUM_PORT_BITS;
    localparam int IDX_BITS = NUM_OUT_PORTS > 1 ? $clog2(NUM_OUT_PORTS) : 1;

    if (PACKET_BITS != 1 + NUM_LEAF_BITS + NUM_PORT_BITS + NUM_ADDR_BITS + PAYLOAD_BITS) begin : g_bad_packet
        $error("PACKET_BITS must equal 1+NUM_LEAF_BITS+NUM_PORT_BITS+NUM_ADDR_BITS+PAYLOAD_BITS");
    end
    if (NUM_OUT_PORTS < 1 || NUM_OUT_PORTS > 16) begin : g_bad_ports
        $error("NUM_OUT_PORTS must be in 1..16");
    end

    logic [PAYLOAD_BITS-1:0]  din_a [NUM_OUT_PORTS];
    logic [DST_BITS-1:0]      dst_a [NUM_OUT_PORTS];
    logic [IDX_BITS-1:0]      last_grant_q, last_grant_d, grant_idx;
    logic [IDX_BITS:0]        cand_w;
    logic [NUM_ADDR_BITS-1:0] seq_q [NUM_OUT_PORTS];
    logic [NUM_ADDR_BITS-1:0] seq_d [NUM_OUT_PORTS];
    logic [CREDIT_BITS-1:0]   credit_q [NUM_OUT_PORTS];
    logic [CREDIT_BITS-1:0]   credit_d [NUM_OUT_PORTS];
    logic [CREDIT_BITS:0]     credit_sum;
    logic [NUM_OUT_PORTS-1:0] credit_empty_q, credit_empty_d;
    logic [PACKET_BITS-1:0]   dout_q, dout_d;
    logic                     load, found;

    for (genvar g = 0; g < NUM_OUT_PORTS; g++) begin : g_unpack
        assign din_a[g] = din_leaf_user2interface[g*PAYLOAD_BITS +: PAYLOAD_BITS];
        assign dst_a[g] = dst_cfg[g*DST_BITS +: DST_BITS];
    end

    always_comb begin
        load      = reset_n && !stall && !resend;
        found     = 1'b0;
        grant_idx = '0;
        cand_w    = '0;
        for (int k = 1; k <= NUM_OUT_PORTS; k++) begin
            cand_w = {1'b0, last_grant_q} + (IDX_BITS+1)'(k);
            if (cand_w >= (IDX_BITS+1)'(NUM_OUT_PORTS))
                cand_w = cand_w - (IDX_BITS+1)'(NUM_OUT_PORTS);
            if (!found && vld_user2interface[cand_w[IDX_BITS-1:0]] && credit_q[cand_w[IDX_BITS-1:0]] != '0) begin
                found     = 1'b1;
                grant_idx = cand_w[IDX_BITS-1:0];
            end
        end
        found = found && load;
        ack_interface2user = '0;
        if (found)
            ack_interface2user[grant_idx] = 1'b1;
        last_grant_d = found ? grant_idx : last_grant_q;
        dout_d = !load ? dout_q :
                 found ? {1'b1, dst_a[grant_idx], seq_q[grant_idx], din_a[grant_idx]} : '0;
        credit_sum = '0;
        for (int i = 0; i < NUM_OUT_PORTS; i++) begin
            // return and grant combine before saturating so a full counter still nets correctly
            credit_sum = {1'b0, credit_q[i]}
                       + ((credit_vld && int'(credit_port) == i) ? {1'b0, credit_amount} : '0)
                       - (CREDIT_BITS+1)'(found && int'(grant_idx) == i);
            credit_d[i]       = credit_sum[CREDIT_BITS] ? '1 : credit_sum[CREDIT_BITS-1:0];
            credit_empty_d[i] = credit_d[i] == '0;
            seq_d[i]          = seq_q[i] + NUM_ADDR_BITS'(found && int'(grant_idx) == i);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            last_grant_q   <= IDX_BITS'(NUM_OUT_PORTS - 1);
            dout_q         <= '0;
            credit_empty_q <= {NUM_OUT_PORTS{CREDIT_INIT == 0}};
            for (int i = 0; i < NUM_OUT_PORTS; i++) begin
                seq_q[i]    <= '0;
                credit_q[i] <= CREDIT_BITS'(CREDIT_INIT);
            end
        end else begin
            last_grant_q   <= last_grant_d;
            dout_q         <= dout_d;
            credit_empty_q <= credit_empty_d;
            seq_q          <= seq_d;
            credit_q       <= credit_d;
        end
    end

    assign dout_leaf_interface2bft = resend ? '0 : dout_q;
    assign credit_empty            = credit_empty_q;
endmodule

// File: tb/tb_leaf_out_arbiter_rr.sv
// tb_leaf_out_arbiter_rr: directed and randomized steps checked against a per-port
// credit/sequence model of the round-robin leaf output arbiter.
module tb_leaf_out_arbiter_rr;
    localparam int N = 6, PW = 32, LB = 5, PB = 4, AB = 7, KB = 49, CB = 8, CI = 64, DB = LB + PB;
    localparam int CMAX = (1 << CB) - 1;

    logic            clk = 1'b0, reset_n = 1'b0;
    logic [N*PW-1:0] din = '0;
    logic [N-1:0]    vld = '0, ack, credit_empty;
    logic [N*DB-1:0] dst_cfg = '0;
    logic            credit_vld = 1'b0, stall = 1'b0, resend = 1'b0;
    logic [PB-1:0]   credit_port = '0;
    logic [CB-1:0]   credit_amount = '0;
    logic [KB-1:0]   dout;

    int errors = 0, checks = 0;
    int m_credit[N], m_seq[N], m_last;
    logic [KB-1:0] m_dout;

    always #5 clk = ~clk;

    leaf_out_arbiter_rr dut (
        .clk(clk), .reset_n(reset_n),
        .din_leaf_user2interface(din), .vld_user2interface(vld), .ack_interface2user(ack),
        .dst_cfg(dst_cfg), .credit_vld(credit_vld), .credit_port(credit_port),
        .credit_amount(credit_amount), .stall(stall), .resend(resend),
        .dout_leaf_interface2bft(dout), .credit_empty(credit_empty)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int pick();
        if (!reset_n || stall || resend) return -1;
        for (int k = 1; k <= N; k++) begin
            int j = (m_last + k) % N;
            if (vld[j] && m_credit[j] > 0) return j;
        end
        return -1;
    endfunction

    function automatic logic [N-1:0] exp_empty();
        logic [N-1:0] e;
        for (int i = 0; i < N; i++) e[i] = m_credit[i] == 0;
        return e;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            m_credit[i] = CI;
            m_seq[i]    = 0;
        end
        m_last = N - 1;
        m_dout = '0;
    endtask

    task automatic rand_din();
        for (int i = 0; i < N; i++) din[i*PW +: PW] = $urandom;
    endtask

    task automatic tick();
        int g, c;
        #1;
        g = pick();
        check("ack", 64'(ack), g >= 0 ? (64'(1) << g) : 64'(0));
        check("dout", 64'(dout), resend ? 64'(0) : 64'(m_dout));
        if (reset_n && !stall && !resend) begin
            m_dout = g >= 0 ? {1'b1, dst_cfg[g*DB +: DB], AB'(m_seq[g]), din[g*PW +: PW]} : '0;
            if (g >= 0) begin
                m_seq[g] = (m_seq[g] + 1) % (1 << AB);
                m_last   = g;
            end
        end
        for (int i = 0; i < N; i++) begin
            c = m_credit[i] - (g == i ? 1 : 0) + ((credit_vld && int'(credit_port) == i) ? int'(credit_amount) : 0);
            m_credit[i] = c > CMAX ? CMAX : c;
        end
        @(posedge clk);
        #1;
        check("credit_empty", 64'(credit_empty), 64'(exp_empty()));
    endtask

    task automatic do_reset();
        #2 reset_n = 1'b0;
        #1;
        check("rst_dout", 64'(dout), 64'(0));
        check("rst_ack", 64'(ack), 64'(0));
        model_reset();
        @(posedge clk);
        #1;
        check("rst_credit_empty", 64'(credit_empty), 64'(0));
        reset_n = 1'b1;
    endtask

    initial begin
        for (int i = 0; i < N; i++) dst_cfg[i*DB +: DB] = DB'($urandom);
        rand_din();
        vld = '1;
        model_reset();
        @(posedge clk);
        #1;
        check("rst_dout", 64'(dout), 64'(0));
        check("rst_ack", 64'(ack), 64'(0));
        check("rst_credit_empty", 64'(credit_empty), 64'(0));
        reset_n = 1'b1;
        // ports 0,2,5 rotate
        vld = 6'b100101;
        repeat (7) begin rand_din(); tick(); end
        // stall holds, then rotation resumes
        vld = '1;
        stall = 1'b1;
        repeat (3) begin rand_din(); tick(); end
        stall = 1'b0;
        repeat (3) begin rand_din(); tick(); end
        // resend blanks output, then the held packet returns
        resend = 1'b1;
        repeat (2) begin rand_din(); tick(); end
        resend = 1'b0;
        repeat (2) tick();
        // drain port 3 then top up by one
        vld = 6'b001000;
        repeat (70) tick();
        check("empty3", 64'(credit_empty[3]), 64'(1));
        credit_vld = 1'b1; credit_port = 4'd3; credit_amount = 8'd1;
        tick();
        credit_vld = 1'b0;
        repeat (4) tick();
        // long run on port 1 for sequence wrap, credit net zero
        vld = 6'b000010;
        credit_vld = 1'b1; credit_port = 4'd1; credit_amount = 8'd1;
        repeat (140) begin rand_din(); tick(); end
        // saturation on port 4, then drain it
        credit_port = 4'd4; credit_amount = 8'd255;
        vld = '0;
        repeat (2) tick();
        credit_vld = 1'b0;
        vld = 6'b010000;
        repeat (258) tick();
        // grant and return on same port together
        vld = 6'b000001;
        credit_vld = 1'b1; credit_port = 4'd0; credit_amount = 8'd4;
        tick();
        credit_vld = 1'b0;
        repeat (80) tick();
        // randomized traffic with a mid-run reset
        for (int n = 0; n < 400; n++) begin
            if (n == 200) do_reset();
            rand_din();
            vld           = N'($urandom);
            stall         = $urandom_range(0, 4) == 0;
            resend        = $urandom_range(0, 9) == 0;
            credit_vld    = $urandom_range(0, 2) == 0;
            credit_port   = PB'($urandom);
            credit_amount = $urandom_range(0, 7) == 0 ? CB'($urandom) : CB'($urandom_range(0, 2));
            tick();
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
